// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared FSM encoding and CRC-8 helpers for cfg_loader
package cfg_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [7:0] CRC_POLY = 8'h07;

    // CRC-8, MSB first, one whole byte folded into the running remainder
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int k = 0; k < 8; k++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/cfg_clkdiv.sv
// rtl/cfg_clkdiv.sv - phase timer: pulses phase_done every DIV cycles while run is high
module cfg_clkdiv #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic phase_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign phase_done = run && (cnt == CW'(DIV - 1));

    // Counter restarts from zero whenever a phase ends or the loader leaves LOW/HIGH,
    // so every LOW or HIGH entry sees a fresh count of exactly DIV cycles.
    always_ff @(posedge clk) begin
        if (reset || !run || phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - byte-stream to serial configuration-chain loader (optional CRC check: CFG_LOADER_CRC_EN)
module cfg_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int DIV       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       prog_clk,
    output logic       ccff_head,
    output logic       busy,
    output logic       done,
    output logic       err
);

    import cfg_pkg::*;

    localparam int BW = $clog2(CHAIN_LEN + 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [6:0]    shreg;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic          phase_done;
    logic          run;
    logic          take;
    logic          last_bit;
    logic          byte_end;
    logic          idle_like;

`ifdef CFG_LOADER_CRC_EN
    logic [7:0]    crc;
`endif

    assign run       = (state == ST_LOW) || (state == ST_HIGH);
    assign take      = in_valid && in_ready;
    assign last_bit  = (bit_cnt == BW'(CHAIN_LEN - 1));
    assign byte_end  = (bit_idx == 3'd7);
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);

`ifdef CFG_LOADER_CRC_EN
    assign in_ready = (state == ST_FETCH) || (state == ST_CHECK);
    assign busy     = (state == ST_FETCH) || run || (state == ST_CHECK);
`else
    assign in_ready = (state == ST_FETCH);
    assign busy     = (state == ST_FETCH) || run;
`endif

    cfg_clkdiv #(.DIV(DIV)) u_clkdiv (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .phase_done (phase_done)
    );

    // Next-state decode; start is only honoured from IDLE or DONE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (take) state_next = ST_LOW;
            end
            ST_LOW: begin
                if (phase_done) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (phase_done) begin
                    if (last_bit) begin
`ifdef CFG_LOADER_CRC_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_DONE;
`endif
                    end else if (byte_end) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_LOW;
                    end
                end
            end
`ifdef CFG_LOADER_CRC_EN
            ST_CHECK: begin
                if (take) state_next = ST_DONE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // State, datapath and status registers; prog_clk is registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            prog_clk  <= 1'b0;
            ccff_head <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc       <= '0;
`endif
        end else begin
            state    <= state_next;
            prog_clk <= (state_next == ST_HIGH);

            if (idle_like && start) begin
                done    <= 1'b0;
                err     <= 1'b0;
                bit_cnt <= '0;
                bit_idx <= '0;
`ifdef CFG_LOADER_CRC_EN
                crc     <= '0;
`endif
            end

            if (state == ST_FETCH && take) begin
                ccff_head <= in_data[7];
                shreg     <= in_data[6:0];
`ifdef CFG_LOADER_CRC_EN
                crc       <= crc8_next(crc, in_data);
`endif
            end

            // Advance one bit at the end of HIGH; surplus pad bits of the last byte are dropped
            if (state == ST_HIGH && phase_done) begin
                bit_cnt <= bit_cnt + BW'(1);
                bit_idx <= bit_idx + 3'd1;
                shreg   <= {shreg[5:0], 1'b0};
                if (!last_bit && !byte_end) begin
                    ccff_head <= shreg[6];
                end
            end

`ifdef CFG_LOADER_CRC_EN
            if (state == ST_CHECK && take) begin
                err <= (in_data != crc);
            end
`endif

            if (state != ST_DONE && state_next == ST_DONE) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - directed vector bench for cfg_loader (CRC paths active with CFG_LOADER_CRC_EN)
module tb_cfg_loader;

`ifdef CFG_LOADER_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start_v = '0;
    logic [2:0] valid_v = '0;
    logic [7:0] data_v [3];
    logic [2:0] ready_v;
    logic [2:0] pclk_v;
    logic [2:0] ccff_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] err_v;

    int nchecks = 0;
    int nerrors = 0;
    int div_of [3] = '{1, 3, 1};

    always #5 clk = ~clk;

    cfg_loader #(.CHAIN_LEN(12), .DIV(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .in_data(data_v[0]), .in_valid(valid_v[0]),
        .in_ready(ready_v[0]), .prog_clk(pclk_v[0]), .ccff_head(ccff_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .err(err_v[0])
    );

    cfg_loader #(.CHAIN_LEN(12), .DIV(3)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .in_data(data_v[1]), .in_valid(valid_v[1]),
        .in_ready(ready_v[1]), .prog_clk(pclk_v[1]), .ccff_head(ccff_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .err(err_v[1])
    );

    cfg_loader #(.CHAIN_LEN(8), .DIV(1)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .in_data(data_v[2]), .in_valid(valid_v[2]),
        .in_ready(ready_v[2]), .prog_clk(pclk_v[2]), .ccff_head(ccff_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .err(err_v[2])
    );

    typedef struct {
        int         inst;
        logic [7:0] b0;
        logic [7:0] b1;
        int         nbytes;
        int         nbits;
        int         stall;
        int         midstart;
        logic [11:0] exp_bits;
        int         exp_lh;
        logic [7:0] crc;
        bit         crc_auto;
        bit         err_crc;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial LFSR form of CRC-8 poly 0x07, used only to build CRC trailer bytes
    function automatic logic [7:0] model_crc(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [7:0] c;
        logic [15:0] s;
        logic fb;
        c = 8'h00;
        s = {b0, b1};
        for (int k = 0; k < 8 * n; k++) begin
            fb = c[7] ^ s[15 - k];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic run_load(input vec_t v, input string tag);
        int i;
        int total;
        int idx;
        int stall;
        int edges;
        int run;
        int bad;
        int stall_bad;
        int lh;
        int cyc;
        bit fin;
        bit prev;
        bit pclk;
        bit ready_prev;
        logic [11:0] cap;
        logic [7:0] bytes [3];
        i = v.inst;
        bytes[0] = v.b0;
        bytes[1] = v.b1;
        bytes[2] = 8'h00;
        total = v.nbytes;
        if (CRC_ON) begin
            bytes[v.nbytes] = v.crc_auto ? model_crc(v.b0, v.b1, v.nbytes) : v.crc;
            total = v.nbytes + 1;
        end
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        check({tag, " start busy/done/err"}, {29'd0, busy_v[i], done_v[i], err_v[i]}, 32'h4);
        idx = 0; stall = v.stall; edges = 0; run = 0; bad = 0; stall_bad = 0; lh = 0;
        cyc = 0; fin = 0; prev = 0; ready_prev = 0; cap = '0;
        while (cyc < 3000) begin
            if (valid_v[i] && ready_prev) idx++;
            pclk = pclk_v[i];
            if (pclk && !prev) begin
                cap = {cap[10:0], ccff_v[i]};
                edges++;
            end
            if (pclk) run++;
            else if (prev) begin
                if (run != div_of[i]) bad++;
                run = 0;
            end
            prev = pclk;
            if (done_v[i]) begin
                fin = 1;
                break;
            end
            if (busy_v[i] && !ready_v[i]) lh++;
            valid_v[i] = 1'b0;
            if (ready_v[i] && idx < total) begin
                if (idx == 1 && stall > 0) begin
                    stall--;
                    if (pclk) stall_bad++;
                end else begin
                    valid_v[i] = 1'b1;
                    data_v[i] = bytes[idx];
                end
            end
            ready_prev = ready_v[i];
            start_v[i] = (cyc == v.midstart);
            @(negedge clk);
            cyc++;
        end
        valid_v[i] = 1'b0;
        start_v[i] = 1'b0;
        check({tag, " finished"}, 32'(fin), 32'd1);
        check({tag, " prog_clk edges"}, edges, v.nbits);
        check({tag, " ccff sequence"}, 32'(cap), 32'(v.exp_bits));
        check({tag, " high width errors"}, bad, 0);
        check({tag, " stall pulses"}, stall_bad, 0);
        check({tag, " low/high cycles"}, lh, v.exp_lh);
        check({tag, " err"}, 32'(err_v[i]), 32'(CRC_ON && v.err_crc));
        check({tag, " idle outputs"}, {29'd0, busy_v[i], ready_v[i], pclk_v[i]}, 32'd0);
    endtask

    initial begin
        int edges;
        bit prev;
        vecs[0] = '{inst:0, b0:8'hA5, b1:8'h3F, nbytes:2, nbits:12, stall:0,  midstart:-1,
                    exp_bits:12'hA53, exp_lh:24, crc:8'h00, crc_auto:1, err_crc:0};
        vecs[1] = '{inst:1, b0:8'hA5, b1:8'h3F, nbytes:2, nbits:12, stall:10, midstart:-1,
                    exp_bits:12'hA53, exp_lh:72, crc:8'h00, crc_auto:1, err_crc:0};
        vecs[2] = '{inst:1, b0:8'hFF, b1:8'h00, nbytes:2, nbits:12, stall:0,  midstart:20,
                    exp_bits:12'hFF0, exp_lh:72, crc:8'h00, crc_auto:1, err_crc:0};
        vecs[3] = '{inst:2, b0:8'h01, b1:8'h00, nbytes:1, nbits:8,  stall:0,  midstart:-1,
                    exp_bits:12'h001, exp_lh:16, crc:8'h06, crc_auto:0, err_crc:1};
        vecs[4] = '{inst:2, b0:8'h01, b1:8'h00, nbytes:1, nbits:8,  stall:0,  midstart:-1,
                    exp_bits:12'h001, exp_lh:16, crc:8'h07, crc_auto:0, err_crc:0};
        for (int k = 0; k < 3; k++) data_v[k] = 8'h00;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset outputs dut%0d", k),
                  {26'd0, ready_v[k], pclk_v[k], ccff_v[k], busy_v[k], done_v[k], err_v[k]}, 32'd0);
        end
        reset = 1'b0;

        for (int k = 0; k < 5; k++) run_load(vecs[k], $sformatf("vec%0d", k));

        // Reset in the middle of a load, after the fifth bit has been clocked out
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        valid_v[0] = 1'b1;
        data_v[0] = 8'hA5;
        @(negedge clk);
        valid_v[0] = 1'b0;
        edges = 0;
        prev = 0;
        for (int c = 0; c < 100 && edges < 5; c++) begin
            if (pclk_v[0] && !prev) edges++;
            prev = pclk_v[0];
            if (edges < 5) @(negedge clk);
        end
        check("midload edges reached", edges, 5);
        reset = 1'b1;
        @(negedge clk);
        check("midload reset outputs",
              {26'd0, ready_v[0], pclk_v[0], ccff_v[0], busy_v[0], done_v[0], err_v[0]}, 32'd0);
        reset = 1'b0;
        run_load(vecs[0], "reload");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
